// File: rtl/mpu_load_sequencer.sv
// ---------------------------------------------------------------------------
// mpu_load_sequencer
//
// Front end of the MPU register file. A load command names a destination
// register and a matrix size. The block then takes a valid/ready stream of
// row-major elements and issues one register-file write per element, tagged
// with its (row, column) location and the matrix size. It pulses done when
// the last element is written. It pulses error instead if the size is illegal.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   load_req_in              start command (sampled only while load_ready_out)
//   load_addr_in             destination register
//   load_m_in / load_n_in    row / column count, legal range 1..M / 1..N
//   load_ready_out           idle, ready for a command
//   elem_valid_in/_data_in   element stream from memory
//   elem_ready_out           stream handshake (high while loading)
//   reg_load_*_out           registered register-file write port
//   load_done_out            one-cycle completion pulse
//   load_error_out           one-cycle illegal-size pulse
// ---------------------------------------------------------------------------
module mpu_load_sequencer #(
    parameter int FP              = 64,
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = $clog2(M),
    parameter int NBITS           = $clog2(N),
    parameter int MATRIX_REG_SIZE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req_in,
    input  logic [MATRIX_REG_SIZE-1:0] load_addr_in,
    input  logic [MBITS:0]             load_m_in,
    input  logic [NBITS:0]             load_n_in,
    output logic                       load_ready_out,
    input  logic                       elem_valid_in,
    input  logic [FP-1:0]              elem_data_in,
    output logic                       elem_ready_out,
    output logic                       reg_load_en_out,
    output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
    output logic [FP-1:0]              reg_load_element_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output logic                       load_done_out,
    output logic                       load_error_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

    state_t state, state_next;

    // Command registers, captured when a command is accepted.
    logic [MATRIX_REG_SIZE-1:0] addr_q;
    logic [MBITS:0]             m_q;
    logic [NBITS:0]             n_q;

    // Row-major position of the next element to be accepted.
    logic [MBITS:0] i_cnt;
    logic [NBITS:0] j_cnt;

    logic cmd_take;
    logic size_legal;
    logic accept;
    logic row_end;
    logic last_elem;

    assign cmd_take   = (state == IDLE) && load_req_in;
    assign size_legal = (load_m_in != '0) && (load_m_in <= M_MAX) &&
                        (load_n_in != '0) && (load_n_in <= N_MAX);
    assign accept     = (state == LOAD) && elem_valid_in;
    assign row_end    = (j_cnt == n_q - (NBITS+1)'(1));
    assign last_elem  = row_end && (i_cnt == m_q - (MBITS+1)'(1));

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: defaulting every comb output first keeps this block free of
        // inferred latches on any path that does not assign it.
        state_next = state;
        case (state)
            IDLE: begin
                if (load_req_in) begin
                    state_next = size_legal ? LOAD : ERROR;
                end
            end
            LOAD: begin
                if (accept && last_elem) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        load_ready_out = 1'b0;
        elem_ready_out = 1'b0;
        load_done_out  = 1'b0;
        load_error_out = 1'b0;
        case (state)
            IDLE:    load_ready_out = 1'b1;
            LOAD:    elem_ready_out = 1'b1;
            DONE:    load_done_out  = 1'b1;
            ERROR:   load_error_out = 1'b1;
            default: load_ready_out = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Command capture, position counters and the registered write port.
    // The write port holds its last values between writes, so the size
    // outputs stay valid until the next load's first write.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q               <= '0;
            m_q                  <= '0;
            n_q                  <= '0;
            i_cnt                <= '0;
            j_cnt                <= '0;
            reg_load_en_out      <= 1'b0;
            reg_load_addr_out    <= '0;
            reg_load_element_out <= '0;
            reg_i_load_loc_out   <= '0;
            reg_j_load_loc_out   <= '0;
            reg_m_load_size_out  <= '0;
            reg_n_load_size_out  <= '0;
        end else begin
            reg_load_en_out <= accept;

            if (cmd_take) begin
                addr_q <= load_addr_in;
                m_q    <= load_m_in;
                n_q    <= load_n_in;
                i_cnt  <= '0;
                j_cnt  <= '0;
            end

            if (accept) begin
                reg_load_addr_out    <= addr_q;
                reg_load_element_out <= elem_data_in;
                reg_i_load_loc_out   <= i_cnt;
                reg_j_load_loc_out   <= j_cnt;
                reg_m_load_size_out  <= m_q;
                reg_n_load_size_out  <= n_q;
                // After the final element i steps to m; harmless, because
                // the next command clears both counters.
                if (row_end) begin
                    j_cnt <= '0;
                    i_cnt <= i_cnt + (MBITS+1)'(1);
                end else begin
                    j_cnt <= j_cnt + (NBITS+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mpu_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mpu_load_sequencer
//
// Directed bench for mpu_load_sequencer with default parameters (4x4, 64-bit
// elements, 2-bit register address). Inputs change and outputs are sampled
// on the falling clock edge. Element k of a load carries the IEEE double
// (base + k + 1), so its expected location and data follow from k alone.
// ---------------------------------------------------------------------------
module tb_mpu_load_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req_in;
    logic [1:0]  load_addr_in;
    logic [2:0]  load_m_in;
    logic [2:0]  load_n_in;
    logic        load_ready_out;
    logic        elem_valid_in;
    logic [63:0] elem_data_in;
    logic        elem_ready_out;
    logic        reg_load_en_out;
    logic [1:0]  reg_load_addr_out;
    logic [63:0] reg_load_element_out;
    logic [2:0]  reg_i_load_loc_out;
    logic [2:0]  reg_j_load_loc_out;
    logic [2:0]  reg_m_load_size_out;
    logic [2:0]  reg_n_load_size_out;
    logic        load_done_out;
    logic        load_error_out;

    int n_checks = 0;
    int n_errors = 0;

    mpu_load_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_req_in          (load_req_in),
        .load_addr_in         (load_addr_in),
        .load_m_in            (load_m_in),
        .load_n_in            (load_n_in),
        .load_ready_out       (load_ready_out),
        .elem_valid_in        (elem_valid_in),
        .elem_data_in         (elem_data_in),
        .elem_ready_out       (elem_ready_out),
        .reg_load_en_out      (reg_load_en_out),
        .reg_load_addr_out    (reg_load_addr_out),
        .reg_load_element_out (reg_load_element_out),
        .reg_i_load_loc_out   (reg_i_load_loc_out),
        .reg_j_load_loc_out   (reg_j_load_loc_out),
        .reg_m_load_size_out  (reg_m_load_size_out),
        .reg_n_load_size_out  (reg_n_load_size_out),
        .load_done_out        (load_done_out),
        .load_error_out       (load_error_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] elem_val(input int base, input int k);
        return $realtobits(real'(base + k + 1));
    endfunction

    // Idle-state outputs, no write in flight.
    task automatic check_idle(input string tag);
        check({tag, "_load_ready"}, 64'(load_ready_out), 64'd1);
        check({tag, "_elem_ready"}, 64'(elem_ready_out), 64'd0);
        check({tag, "_en"},         64'(reg_load_en_out), 64'd0);
        check({tag, "_done"},       64'(load_done_out),  64'd0);
        check({tag, "_error"},      64'(load_error_out), 64'd0);
    endtask

    // Full load from IDLE (called on a falling edge). With gaps=1, valid is
    // dropped on every other cycle. With intrude=1, a conflicting command is
    // driven during the load and must be ignored. Returns on a falling edge
    // with the sequencer back in IDLE.
    task automatic run_load(input logic [1:0] addr, input int m, input int n,
                            input bit gaps, input bit intrude, input int base);
        int  total  = m * n;
        int  sent   = 0;
        int  wr     = 0;
        int  cyc    = 0;
        bit  exp_en;
        load_req_in  = 1'b1;
        load_addr_in = addr;
        load_m_in    = 3'(m);
        load_n_in    = 3'(n);
        @(negedge clk);
        load_req_in = 1'b0;
        check("load_entry_elem_ready", 64'(elem_ready_out), 64'd1);
        check("load_entry_load_ready", 64'(load_ready_out), 64'd0);
        check("load_entry_en",         64'(reg_load_en_out), 64'd0);
        while (wr < total && cyc < 200) begin
            if (intrude && cyc == 1) begin
                load_req_in  = 1'b1;
                load_addr_in = ~addr;
                load_m_in    = 3'd1;
                load_n_in    = 3'd1;
            end else begin
                load_req_in = 1'b0;
            end
            if (sent < total && !(gaps && cyc[0])) begin
                elem_valid_in = 1'b1;
                elem_data_in  = elem_val(base, sent);
                exp_en        = 1'b1;
                sent++;
            end else begin
                elem_valid_in = 1'b0;
                elem_data_in  = '1;
                exp_en        = 1'b0;
            end
            @(negedge clk);
            cyc++;
            check("wr_en", 64'(reg_load_en_out), 64'(exp_en));
            check("done_timing", 64'(load_done_out), 64'(exp_en && wr == total - 1));
            if (exp_en) begin
                check("wr_addr", 64'(reg_load_addr_out),   64'(addr));
                check("wr_i",    64'(reg_i_load_loc_out),  64'(wr / n));
                check("wr_j",    64'(reg_j_load_loc_out),  64'(wr % n));
                check("wr_m",    64'(reg_m_load_size_out), 64'(m));
                check("wr_n",    64'(reg_n_load_size_out), 64'(n));
                check("wr_data", reg_load_element_out,     elem_val(base, wr));
                wr++;
            end
        end
        load_req_in   = 1'b0;
        elem_valid_in = 1'b0;
        check("done_state_elem_ready", 64'(elem_ready_out), 64'd0);
        check("done_state_load_ready", 64'(load_ready_out), 64'd0);
        @(negedge clk);
        check_idle("post_load");
    endtask

    // Illegal command from IDLE: one error cycle, then IDLE; stream offered
    // throughout must never be taken.
    task automatic run_error(input int m, input int n);
        load_req_in   = 1'b1;
        load_addr_in  = 2'd2;
        load_m_in     = 3'(m);
        load_n_in     = 3'(n);
        elem_valid_in = 1'b1;
        elem_data_in  = 64'hdead_beef;
        @(negedge clk);
        load_req_in = 1'b0;
        check("err_pulse",      64'(load_error_out), 64'd1);
        check("err_elem_ready", 64'(elem_ready_out), 64'd0);
        check("err_load_ready", 64'(load_ready_out), 64'd0);
        check("err_en",         64'(reg_load_en_out), 64'd0);
        check("err_done",       64'(load_done_out),  64'd0);
        @(negedge clk);
        check_idle("err_after");
        elem_valid_in = 1'b0;
        @(negedge clk);
        check_idle("err_idle_stream");
    endtask

    initial begin
        rst           = 1'b1;
        load_req_in   = 1'b0;
        load_addr_in  = '0;
        load_m_in     = '0;
        load_n_in     = '0;
        elem_valid_in = 1'b0;
        elem_data_in  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_m_size", 64'(reg_m_load_size_out), 64'd0);
        check("reset_n_size", 64'(reg_n_load_size_out), 64'd0);
        check("reset_addr",   64'(reg_load_addr_out),   64'd0);
        rst = 1'b0;

        // Stream offered in IDLE is not accepted.
        elem_valid_in = 1'b1;
        elem_data_in  = 64'h1234;
        @(negedge clk);
        check_idle("idle_stream");
        elem_valid_in = 1'b0;

        // 2x3 to reg 1, continuous, data 1.0..6.0.
        run_load(2'd1, 2, 3, 1'b0, 1'b0, 0);

        // 4x4 with valid gaps every other cycle.
        run_load(2'd2, 4, 4, 1'b1, 1'b0, 100);

        // Illegal sizes: m=0 and m=5.
        run_error(0, 2);
        run_error(5, 4);

        // Conflicting command during a 2x2 load is ignored.
        run_load(2'd3, 2, 2, 1'b0, 1'b1, 200);

        // Asynchronous reset after 3 of 9 elements of a 3x3 load.
        load_req_in  = 1'b1;
        load_addr_in = 2'd2;
        load_m_in    = 3'd3;
        load_n_in    = 3'd3;
        @(negedge clk);
        load_req_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            elem_valid_in = 1'b1;
            elem_data_in  = elem_val(300, k);
            @(negedge clk);
            check("pre_rst_en", 64'(reg_load_en_out),    64'd1);
            check("pre_rst_j",  64'(reg_j_load_loc_out), 64'(k));
        end
        elem_valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_en",         64'(reg_load_en_out),     64'd0);
        check("arst_load_ready", 64'(load_ready_out),      64'd1);
        check("arst_elem_ready", 64'(elem_ready_out),      64'd0);
        check("arst_j",          64'(reg_j_load_loc_out),  64'd0);
        check("arst_m_size",     64'(reg_m_load_size_out), 64'd0);
        check("arst_data",       reg_load_element_out,     64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_load(2'd1, 1, 1, 1'b0, 1'b0, 400);

        // Back-to-back: 1x2 to reg 0, then 2x1 to reg 3 as ready returns.
        run_load(2'd0, 1, 2, 1'b0, 1'b0, 500);
        run_load(2'd3, 2, 1, 1'b0, 1'b0, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
